// File: rtl/suprloco_cpu_bus.sv
// suprloco_cpu_bus: main-CPU bus controller for Super Locomotive.
// Generates CPU clock enables and decodes the Z80 address space. ROM bytes
// arrive through a req/ack port behind a one-byte cache, stretching the CPU
// with WAIT_n. Also holds the 4 KB work RAM and the vblank interrupt.
// Ports:
//   i_CLK, i_RST_n            master clock, synchronous active-low reset
//   o_PCEN, o_NCEN            CPU clock enables
//   o_WAIT_n, o_INT_n         CPU wait and interrupt
//   i_ADDR, i_DO, strobes     CPU bus
//   o_DI                      read data to the CPU wrapper
//   o_ROM_*, i_ROM_*          program ROM fetch port
//   o_EXT_CS, i_EXT_DATA      video-side memory window C000-DFFF
//   o_IO_RD, o_IO_WR, i_IO_DATA  I/O port strobes and read data
//   i_VBLANK                  vertical blank
module suprloco_cpu_bus #(
    parameter int CEN_DIV = 4
) (
    input  logic        i_CLK,
    input  logic        i_RST_n,
    output logic        o_PCEN,
    output logic        o_NCEN,
    output logic        o_WAIT_n,
    output logic        o_INT_n,
    input  logic [15:0] i_ADDR,
    input  logic        i_MREQ_n,
    input  logic        i_IORQ_n,
    input  logic        i_RD_n,
    input  logic        i_WR_n,
    input  logic        i_M1_n,
    input  logic        i_RFSH_n,
    input  logic [7:0]  i_DO,
    output logic [7:0]  o_DI,
    output logic [15:0] o_ROM_ADDR,
    output logic        o_ROM_RQ,
    input  logic        i_ROM_ACK,
    input  logic [7:0]  i_ROM_DATA,
    output logic        o_EXT_CS,
    input  logic [7:0]  i_EXT_DATA,
    output logic        o_IO_RD,
    output logic        o_IO_WR,
    input  logic [7:0]  i_IO_DATA,
    input  logic        i_VBLANK
);

    localparam int CW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        pcen_q, pcen_d;
    logic        ncen_q, ncen_d;
    logic        rq_q, rq_d;
    logic        wait_n_q, wait_n_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [15:0] tag_q, tag_d;
    logic [7:0]  cache_q, cache_d;
    logic        valid_q, valid_d;
    logic        io_wr_q, io_wr_d;
    logic        io_wr_prev_q, io_wr_prev_d;
    logic        vbl_q, vbl_d;
    logic        vbl_prev_q, vbl_prev_d;
    logic        irq_q, irq_d;
    logic        int_n_q, int_n_d;

    logic [7:0]  ram_q [0:4095];
    logic [7:0]  ram_rd_q;

    logic mem_acc, mem_rd, rom_sel, ext_sel, ram_sel;
    logic rom_rd, hit, ack_cyc, io_rd, io_wr_lvl, ram_we;

    always_comb begin
        mem_acc   = ~i_MREQ_n & i_RFSH_n;
        mem_rd    = mem_acc & ~i_RD_n;
        rom_sel   = i_ADDR[15:14] != 2'b11;
        ext_sel   = i_ADDR[15:13] == 3'b110;
        ram_sel   = i_ADDR[15:12] == 4'hE;
        rom_rd    = mem_rd & rom_sel;
        hit       = valid_q & (tag_q == i_ADDR);
        ack_cyc   = ~i_IORQ_n & ~i_M1_n;
        io_rd     = ~i_IORQ_n & ~i_RD_n & i_M1_n;
        io_wr_lvl = ~i_IORQ_n & ~i_WR_n;
        ram_we    = mem_acc & ~i_WR_n & ram_sel;
    end

    always_comb begin
        cnt_d      = (cnt_q == CW'(CEN_DIV - 1)) ? '0 : cnt_q + CW'(1);
        pcen_d     = cnt_q == CW'(CEN_DIV - 1);
        ncen_d     = cnt_q == CW'(CEN_DIV / 2 - 1);
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        tag_d      = tag_q;
        cache_d    = cache_q;
        valid_d    = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rom_rd) begin
                    if (hit) begin
                        state_d = ST_HOLD;
                    end else begin
                        rom_addr_d = i_ADDR;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_ROM_ACK) begin
                    cache_d = i_ROM_DATA;
                    tag_d   = rom_addr_q;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_MREQ_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs follow the next state so WAIT_n falls one clock after detect.
        rq_d     = state_d == ST_REQ;
        wait_n_d = ~((state_d == ST_REQ) | (state_d == ST_WAIT));

        io_wr_prev_d = io_wr_lvl;
        io_wr_d      = io_wr_lvl & ~io_wr_prev_q;

        // Two-stage edge detect; acknowledge beats a simultaneous edge.
        vbl_d      = i_VBLANK;
        vbl_prev_d = vbl_q;
        if (ack_cyc) begin
            irq_d = 1'b0;
        end else if (vbl_q & ~vbl_prev_q) begin
            irq_d = 1'b1;
        end else begin
            irq_d = irq_q;
        end
        int_n_d = ~irq_d;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pcen_q       <= 1'b0;
            ncen_q       <= 1'b0;
            rq_q         <= 1'b0;
            wait_n_q     <= 1'b1;
            rom_addr_q   <= '0;
            tag_q        <= '0;
            cache_q      <= '0;
            valid_q      <= 1'b0;
            io_wr_q      <= 1'b0;
            io_wr_prev_q <= 1'b0;
            vbl_q        <= 1'b0;
            vbl_prev_q   <= 1'b0;
            irq_q        <= 1'b0;
            int_n_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pcen_q       <= pcen_d;
            ncen_q       <= ncen_d;
            rq_q         <= rq_d;
            wait_n_q     <= wait_n_d;
            rom_addr_q   <= rom_addr_d;
            tag_q        <= tag_d;
            cache_q      <= cache_d;
            valid_q      <= valid_d;
            io_wr_q      <= io_wr_d;
            io_wr_prev_q <= io_wr_prev_d;
            vbl_q        <= vbl_d;
            vbl_prev_q   <= vbl_prev_d;
            irq_q        <= irq_d;
            int_n_q      <= int_n_d;
        end
    end

    // Work RAM keeps its contents through reset.
    always_ff @(posedge i_CLK) begin
        if (ram_we) ram_q[i_ADDR[11:0]] <= i_DO;
        ram_rd_q <= ram_q[i_ADDR[11:0]];
    end

    always_comb begin
        if (!i_RST_n) begin
            o_DI = 8'hFF;
        end else if (ack_cyc) begin
            o_DI = 8'hFF;
        end else if (io_rd) begin
            o_DI = i_IO_DATA;
        end else if (mem_rd & rom_sel) begin
            o_DI = cache_q;
        end else if (mem_rd & ext_sel) begin
            o_DI = i_EXT_DATA;
        end else if (mem_rd & ram_sel) begin
            o_DI = ram_rd_q;
        end else begin
            o_DI = 8'hFF;
        end
    end

    assign o_PCEN     = pcen_q;
    assign o_NCEN     = ncen_q;
    assign o_WAIT_n   = wait_n_q;
    assign o_INT_n    = int_n_q;
    assign o_ROM_ADDR = rom_addr_q;
    assign o_ROM_RQ   = rq_q;
    assign o_EXT_CS   = mem_acc & ext_sel;
    assign o_IO_RD    = io_rd;
    assign o_IO_WR    = io_wr_q;

endmodule

// File: tb/tb_suprloco_cpu_bus.sv
// Bench for suprloco_cpu_bus: directed bus cycles, a behavioural model of
// the expected outputs, and a per-cycle compare process.
module tb_suprloco_cpu_bus;

    localparam int CEN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcen, ncen, wait_n, int_n;
    logic [15:0] addr;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [7:0]  dout, di;
    logic [15:0] rom_addr;
    logic        rom_rq, rom_ack;
    logic [7:0]  rom_data;
    logic        ext_cs;
    logic [7:0]  ext_data;
    logic        io_rd, io_wr;
    logic [7:0]  io_data;
    logic        vblank;

    int total = 0;
    int bad = 0;
    int rq_count = 0;
    int iowr_count = 0;

    suprloco_cpu_bus #(.CEN_DIV(CEN)) dut (
        .i_CLK(clk), .i_RST_n(rst_n),
        .o_PCEN(pcen), .o_NCEN(ncen),
        .o_WAIT_n(wait_n), .o_INT_n(int_n),
        .i_ADDR(addr), .i_MREQ_n(mreq_n), .i_IORQ_n(iorq_n),
        .i_RD_n(rd_n), .i_WR_n(wr_n), .i_M1_n(m1_n), .i_RFSH_n(rfsh_n),
        .i_DO(dout), .o_DI(di),
        .o_ROM_ADDR(rom_addr), .o_ROM_RQ(rom_rq),
        .i_ROM_ACK(rom_ack), .i_ROM_DATA(rom_data),
        .o_EXT_CS(ext_cs), .i_EXT_DATA(ext_data),
        .o_IO_RD(io_rd), .o_IO_WR(io_wr), .i_IO_DATA(io_data),
        .i_VBLANK(vblank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: bus-cycle view of the fetch, interrupt and RAM.
    int          m_edges = 0;
    logic        m_seen = 1'b0;
    logic        m_out = 1'b0, m_first = 1'b0, m_hand = 1'b0;
    logic        m_cv = 1'b0, m_rq = 1'b0, m_ak = 1'b0;
    logic [15:0] m_addr = '0, m_tag = '0;
    logic [7:0]  m_cd = '0;
    logic        m_irq = 1'b0, m_pend = 1'b0, m_lastvb = 1'b0;
    logic        m_iowr = 1'b0, m_wrlast = 1'b0;
    logic [7:0]  mem_m [4096];
    bit          mem_k [4096];
    logic [7:0]  m_ramv = '0;
    bit          m_ramk = 1'b0;
    logic [11:0] m_rama = '0;

    always @(posedge clk) begin
        m_seen <= 1'b1;
        if (!rst_n) begin
            m_edges  <= 0;
            m_out    <= 1'b0;
            m_first  <= 1'b0;
            m_hand   <= 1'b0;
            m_cv     <= 1'b0;
            m_rq     <= 1'b0;
            m_ak     <= 1'b0;
            m_irq    <= 1'b0;
            m_pend   <= 1'b0;
            m_lastvb <= 1'b0;
            m_iowr   <= 1'b0;
            m_wrlast <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            m_rq    <= 1'b0;
            if (m_out) begin
                // the request clock itself never accepts an ack
                if (!m_first && rom_ack) begin
                    m_cv   <= 1'b1;
                    m_tag  <= m_addr;
                    m_cd   <= rom_data;
                    m_out  <= 1'b0;
                    m_hand <= 1'b1;
                end
                m_first <= 1'b0;
            end else if (m_hand) begin
                if (mreq_n) m_hand <= 1'b0;
            end else if (!mreq_n && rfsh_n && !rd_n && addr < 16'hC000) begin
                if (m_cv && m_tag == addr) begin
                    m_hand <= 1'b1;
                end else begin
                    m_out   <= 1'b1;
                    m_first <= 1'b1;
                    m_addr  <= addr;
                    m_ak    <= 1'b1;
                    m_rq    <= 1'b1;
                end
            end
            if (!iorq_n && !m1_n) m_irq <= 1'b0;
            else if (m_pend) m_irq <= 1'b1;
            m_pend   <= vblank && !m_lastvb;
            m_lastvb <= vblank;
            m_iowr   <= !iorq_n && !wr_n && !m_wrlast;
            m_wrlast <= !iorq_n && !wr_n;
        end
        m_ramv <= mem_m[addr[11:0]];
        m_ramk <= mem_k[addr[11:0]];
        m_rama <= addr[11:0];
        if (!mreq_n && rfsh_n && !wr_n && addr[15:12] == 4'hE) begin
            mem_m[addr[11:0]] <= dout;
            mem_k[addr[11:0]] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_seen) begin
            automatic logic memrd = !mreq_n && rfsh_n && !rd_n;
            if (rom_rq) rq_count++;
            if (io_wr) iowr_count++;
            chk("pcen", pcen, m_edges > 0 && m_edges % CEN == 0);
            chk("ncen", ncen, m_edges % CEN == CEN / 2);
            chk("wait_n", wait_n, !m_out);
            chk("rom_rq", rom_rq, m_rq);
            chk("int_n", int_n, !m_irq);
            chk("io_wr", io_wr, m_iowr);
            chk("io_rd", io_rd, !iorq_n && !rd_n && m1_n);
            chk("ext_cs", ext_cs,
                !mreq_n && rfsh_n && addr >= 16'hC000 && addr < 16'hE000);
            if (m_ak) chk("rom_addr", rom_addr, m_addr);
            if (!rst_n) chk("di_rst", di, 8'hFF);
            else if (!iorq_n && !m1_n) chk("di_ack", di, 8'hFF);
            else if (!iorq_n && !rd_n && m1_n) chk("di_io", di, io_data);
            else if (memrd && addr < 16'hC000) begin
                if (m_cv && !m_out) chk("di_rom", di, m_cd);
            end else if (memrd && addr < 16'hE000) chk("di_ext", di, ext_data);
            else if (memrd && addr < 16'hF000) begin
                if (m_ramk && m_rama == addr[11:0]) chk("di_ram", di, m_ramv);
            end else chk("di_none", di, 8'hFF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic mem_read(input logic [15:0] a);
        addr = a; mreq_n = 1'b0; rd_n = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic pc [13];
    logic nc [13];
    int   rq0;
    int   wr0;

    initial begin
        idle();
        rst_n = 1'b0; addr = '0; dout = '0; rom_ack = 1'b0; rom_data = '0;
        ext_data = 8'h3C; io_data = 8'h77; vblank = 1'b0;
        repeat (3) tick();
        chk("rst_wait", wait_n, 1'b1);
        chk("rst_int", int_n, 1'b1);
        chk("rst_di", di, 8'hFF);
        chk("rst_pcen", pcen, 1'b0);
        chk("rst_rq", rom_rq, 1'b0);
        rst_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            pc[n] = pcen;
            nc[n] = ncen;
        end
        chk("pcen_e3", pc[3], 1'b0);
        chk("pcen_e4", pc[4], 1'b1);
        chk("pcen_e8", pc[8], 1'b1);
        chk("ncen_e4", nc[4], 1'b0);
        chk("ncen_e6", nc[6], 1'b1);

        // miss at 1234, ack five clocks after the request
        rq0 = rq_count;
        mem_read(16'h1234);
        tick();
        chk("miss_rq", rom_rq, 1'b1);
        chk("miss_addr", rom_addr, 16'h1234);
        chk("miss_wait", wait_n, 1'b0);
        repeat (5) tick();
        chk("miss_hold", wait_n, 1'b0);
        rom_ack = 1'b1; rom_data = 8'hA5;
        tick();
        rom_ack = 1'b0; rom_data = 8'h00;
        chk("miss_wrise", wait_n, 1'b1);
        chk("miss_di", di, 8'hA5);
        idle();
        repeat (2) tick();
        chk("miss_nrq", rq_count - rq0, 1);

        // hit at 1234
        rq0 = rq_count;
        mem_read(16'h1234);
        tick();
        chk("hit_wait", wait_n, 1'b1);
        chk("hit_di", di, 8'hA5);
        repeat (2) tick();
        idle();
        tick();
        chk("hit_nrq", rq_count - rq0, 0);

        // refresh with RD low must not touch the ROM side
        addr = 16'h0012; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
        repeat (3) tick();
        idle();
        tick();
        mem_read(16'h1234);
        tick();
        chk("rfsh_tag_di", di, 8'hA5);
        idle();
        tick();
        chk("rfsh_nrq", rq_count - rq0, 0);

        // RAM, EXT, unmapped
        addr = 16'hE123; dout = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
        tick();
        idle();
        tick();
        mem_read(16'hE123);
        tick();
        chk("ram_di", di, 8'h5A);
        mem_read(16'hF000);
        tick();
        chk("unmap_di", di, 8'hFF);
        mem_read(16'hC100);
        tick();
        chk("ext_di", di, 8'h3C);
        chk("ext_cs", ext_cs, 1'b1);
        idle();
        tick();

        // I/O read and write
        addr = 16'h0042; iorq_n = 1'b0; rd_n = 1'b0;
        tick();
        chk("io_rd_lvl", io_rd, 1'b1);
        chk("io_di", di, 8'h77);
        idle();
        tick();
        wr0 = iowr_count;
        iorq_n = 1'b0; wr_n = 1'b0;
        tick();
        chk("io_wr_p", io_wr, 1'b1);
        repeat (3) tick();
        idle();
        tick();
        chk("io_wr_n", iowr_count - wr0, 1);

        // vblank interrupt
        vblank = 1'b1;
        tick();
        chk("int_e0", int_n, 1'b1);
        tick();
        chk("int_e1", int_n, 1'b0);
        repeat (100) tick();
        chk("int_held", int_n, 1'b0);
        iorq_n = 1'b0; m1_n = 1'b0;
        tick();
        chk("int_ack", int_n, 1'b1);
        chk("ack_di", di, 8'hFF);
        idle();

        // edge and ack on the same clock
        vblank = 1'b0;
        repeat (2) tick();
        vblank = 1'b1;
        tick();
        iorq_n = 1'b0; m1_n = 1'b0;
        tick();
        idle();
        repeat (3) tick();
        chk("int_tie", int_n, 1'b1);

        // reset during a miss, then a stale ack
        mem_read(16'h3000);
        tick();
        chk("mf_rq", rom_rq, 1'b1);
        repeat (2) tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mf_wait", wait_n, 1'b1);
        tick();
        rq0 = rq_count;
        rom_ack = 1'b1; rom_data = 8'h99;
        tick();
        rom_ack = 1'b0;
        chk("mf_stale_w", wait_n, 1'b1);
        chk("mf_stale_r", rom_rq, 1'b0);
        mem_read(16'h1234);
        tick();
        chk("mf_inval", rom_rq, 1'b1);
        repeat (2) tick();
        rom_ack = 1'b1; rom_data = 8'h11;
        tick();
        rom_ack = 1'b0;
        chk("mf_di1", di, 8'h11);
        idle();
        tick();
        mem_read(16'h3000);
        tick();
        chk("mf_again", rom_rq, 1'b1);
        repeat (3) tick();
        rom_ack = 1'b1; rom_data = 8'h22;
        tick();
        rom_ack = 1'b0;
        chk("mf_di2", di, 8'h22);
        idle();
        repeat (2) tick();
        chk("mf_nrq", rq_count - rq0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
